matrix_result_uart_tx: RTL and testbench

//  Return path of the 10x10 matrix pipeline. Captures the 400-bit packed product
//  (100 entries x 4 bits) from the multiplier and streams it to the host over a

---
 rtl/matrix_result_uart_tx.sv | 183 ++++++++++++++++++
 tb/tb_matrix_result_uart_tx.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/matrix_result_uart_tx.sv
// ----------------------------------------------------------------------------
// matrix_result_uart_tx
//   Return path of the 10x10 matrix pipeline. On a start pulse the packed
//   product is copied into a shadow register and streamed out as UART 8N1,
//   one byte per entry, entry 0 first.
//
//   Optional feature (define MATRIX_TX_ASCII_EN): each entry is sent as an
//   ASCII hex digit and every ROW_LEN entries are followed by CR, LF.
//   Without the macro, raw bytes {zeros, entry} are sent and no CR/LF logic
//   exists.
//
// Ports
//   clk    in  1                   system clock, rising edge
//   rst    in  1                   asynchronous reset, active-high
//   start  in  1                   capture result and begin transmission (IDLE only)
//   result in  N_ENTRIES*ENTRY_W   packed product, entry k = result[k*ENTRY_W +: ENTRY_W]
//   tx     out 1                   UART serial line, idles high
//   busy   out 1                   high from the cycle after capture to the last stop bit
//   done   out 1                   one-cycle pulse after the final stop bit
// ----------------------------------------------------------------------------
module matrix_result_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int N_ENTRIES    = 100,
`ifdef MATRIX_TX_ASCII_EN
  parameter int ENTRY_W      = 4,
  parameter int ROW_LEN      = 10
`else
  parameter int ENTRY_W      = 4
`endif
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [N_ENTRIES*ENTRY_W-1:0]   result,
  output logic                           tx,
  output logic                           busy,
  output logic                           done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_STOP = CW'(CLKS_PER_BIT - 2);
  localparam logic [IW-1:0] IDX_LAST = IW'(N_ENTRIES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START_BIT, S_DATA, S_STOP_BIT, S_NEXT, S_FINISH
  } state_t;

  state_t                         r_state;
  state_t                         w_next;
  logic [CW-1:0]                  r_cnt;
  logic [2:0]                     r_bit;
  logic [IW-1:0]                  r_idx;
  logic [N_ENTRIES*ENTRY_W-1:0]   r_shadow;
  logic [ENTRY_W-1:0]             w_entry;
  logic [7:0]                     w_byte;
  logic                           w_last;

  assign w_entry = r_shadow[r_idx*ENTRY_W +: ENTRY_W];

`ifdef MATRIX_TX_ASCII_EN
  localparam int RW = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
  localparam logic [RW-1:0] COL_LAST = RW'(ROW_LEN - 1);

  // r_sub selects what the current frame carries: 0 entry digit, 1 CR, 2 LF
  logic [1:0]    r_sub;
  logic [RW-1:0] r_col;

  function automatic logic [7:0] hex_ascii(input logic [3:0] v);
    return (v < 4'd10) ? (8'h30 + {4'h0, v}) : (8'h37 + {4'h0, v});
  endfunction

  always_comb begin
    w_byte = hex_ascii(4'(w_entry));
    if (r_sub == 2'd1)      w_byte = 8'h0D;
    else if (r_sub == 2'd2) w_byte = 8'h0A;
  end

  // A trailing partial row (N_ENTRIES not a multiple of ROW_LEN) ends on a digit
  assign w_last = (r_idx == IDX_LAST) &&
                  ((r_sub == 2'd2) || ((r_sub == 2'd0) && (r_col != COL_LAST)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sub <= 2'd0;
      r_col <= '0;
    end else if (r_state == S_FINISH) begin
      r_sub <= 2'd0;
      r_col <= '0;
    end else if (r_state == S_NEXT && !w_last) begin
      case (r_sub)
        2'd0: begin
          if (r_col == COL_LAST) begin
            r_sub <= 2'd1;
            r_col <= '0;
          end else begin
            r_col <= r_col + 1'b1;
          end
        end
        2'd1:    r_sub <= 2'd2;
        default: r_sub <= 2'd0;
      endcase
    end
  end

  // The pointer moves after a digit that does not end a row, or after LF
  logic w_adv;
  assign w_adv = ((r_sub == 2'd0) && (r_col != COL_LAST)) || (r_sub == 2'd2);
`else
  assign w_byte = 8'(w_entry);
  assign w_last = (r_idx == IDX_LAST);

  logic w_adv;
  assign w_adv = 1'b1;
`endif

  // Shadow holds the product for the whole transmission; no reset needed
  // because it is always rewritten before use.
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && start)
      r_shadow <= result;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Stop bit is split: STOP_BIT covers its first CLKS_PER_BIT-1 cycles and
  // NEXT is its final cycle, so frames follow each other with no gap.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (start) w_next = S_START_BIT;
      S_START_BIT: if (r_cnt == CNT_MAX) w_next = S_DATA;
      S_DATA:      if (r_cnt == CNT_MAX && r_bit == 3'd7) w_next = S_STOP_BIT;
      S_STOP_BIT:  if (r_cnt == CNT_STOP) w_next = S_NEXT;
      S_NEXT:      w_next = w_last ? S_FINISH : S_START_BIT;
      S_FINISH:    w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_bit <= 3'd0;
      r_idx <= '0;
    end else begin
      case (r_state)
        S_START_BIT: r_cnt <= (r_cnt == CNT_MAX) ? '0 : r_cnt + 1'b1;
        S_DATA: begin
          if (r_cnt == CNT_MAX) begin
            r_cnt <= '0;
            r_bit <= r_bit + 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_STOP_BIT:  r_cnt <= (r_cnt == CNT_STOP) ? '0 : r_cnt + 1'b1;
        S_NEXT:      if (!w_last && w_adv) r_idx <= r_idx + 1'b1;
        S_FINISH: begin
          r_cnt <= '0;
          r_bit <= 3'd0;
          r_idx <= '0;
        end
        default: ;
      endcase
    end
  end

  // Outputs decode the state register directly so reset forces tx high at once
  always_comb begin
    tx = 1'b1;
    if (r_state == S_START_BIT) tx = 1'b0;
    else if (r_state == S_DATA) tx = w_byte[r_bit];
  end

  assign busy = (r_state != S_IDLE) && (r_state != S_FINISH);
  assign done = (r_state == S_FINISH);

endmodule

// File: tb/tb_matrix_result_uart_tx.sv
module tb_matrix_result_uart_tx;

  localparam int CPB = 4;
  localparam int NE  = 100;
  localparam int FRAME = 10 * CPB;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [NE*4-1:0] result = '0;
  logic           tx, busy, done;

  int checks = 0;
  int errors = 0;
  int nfr;
  logic [7:0] exp_b [0:119];
  logic [7:0] dec_b [0:119];

  always #5 clk = ~clk;

  matrix_result_uart_tx #(.CLKS_PER_BIT(CPB), .N_ENTRIES(NE), .ENTRY_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .result(result),
    .tx(tx), .busy(busy), .done(done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] hex_digit(input logic [3:0] v);
    return (v < 4'd10) ? (8'h30 + {4'h0, v}) : (8'h41 + {4'h0, v} - 8'd10);
  endfunction

  task automatic build_exp(input logic [NE*4-1:0] res);
    int n = 0;
    for (int k = 0; k < NE; k++) begin
`ifdef MATRIX_TX_ASCII_EN
      exp_b[n] = hex_digit(res[k*4 +: 4]); n++;
      if (k % 10 == 9) begin
        exp_b[n] = 8'h0D; n++;
        exp_b[n] = 8'h0A; n++;
      end
`else
      exp_b[n] = {4'h0, res[k*4 +: 4]}; n++;
`endif
    end
    nfr = n;
  endtask

  // Pulses start, then checks nframes frames cycle by cycle; with to_end it
  // also checks the done/busy behaviour right after the final stop bit.
  // A second start with inj_res is pulsed at offset inj_cycle (if >= 0).
  task automatic run(input logic [NE*4-1:0] res, input int nframes, input bit to_end,
                     input int inj_cycle, input logic [NE*4-1:0] inj_res);
    int glitches = 0;
    int dones = 0;
    int busylow = 0;
    int total;
    logic expw;
    build_exp(res);
    total = to_end ? nfr : nframes;
    result = res;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_capture", busy, 1'b1);
    for (int f = 0; f < total; f++) begin
      for (int c = 0; c < FRAME; c++) begin
        if (c < CPB) expw = 1'b0;
        else if (c < 9 * CPB) expw = exp_b[f][(c - CPB) / CPB];
        else expw = 1'b1;
        if (tx !== expw) glitches++;
        if (c >= CPB && c < 9 * CPB && ((c - CPB) % CPB) == CPB / 2)
          dec_b[f][(c - CPB) / CPB] = tx;
        if (done !== 1'b0) dones++;
        if (busy !== 1'b1) busylow++;
        if (f * FRAME + c == inj_cycle) begin
          result = inj_res;
          start = 1'b1;
        end else begin
          start = 1'b0;
        end
        @(negedge clk);
      end
      check($sformatf("byte%0d", f), dec_b[f], exp_b[f]);
    end
    start = 1'b0;
    check("waveform_cycle_errors", glitches, 0);
    check("done_early_pulses", dones, 0);
    check("busy_dropped_cycles", busylow, 0);
    if (to_end) begin
      check("done_at_end", done, 1'b1);
      check("busy_low_at_done", busy, 1'b0);
      check("tx_idle_at_done", tx, 1'b1);
      @(negedge clk);
      check("done_one_cycle", done, 1'b0);
      check("busy_idle_after", busy, 1'b0);
    end
  endtask

  logic [NE*4-1:0] r_a, r_mod, r_ff, r_b;
  int lowcnt;

  initial begin
    for (int k = 0; k < NE; k++) begin
      r_mod[k*4 +: 4] = 4'(k % 11);
      r_ff[k*4 +: 4]  = 4'hF - 4'(k % 3);
      r_b[k*4 +: 4]   = 4'((k * 7) % 16);
    end

    // Reset state and idle line
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    rst = 1'b0;
    lowcnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) lowcnt++;
    end
    check("idle_not_high_cycles", lowcnt, 0);

    // Single non-zero entry: first frame 0x03, second 0x00
    r_a = '0;
    r_a[3:0] = 4'h3;
    run(r_a, 0, 1'b1, -1, '0);
`ifdef MATRIX_TX_ASCII_EN
    check("raw_byte0", dec_b[0], 8'h33);
    check("raw_byte1", dec_b[1], 8'h30);
`else
    check("raw_byte0", dec_b[0], 8'h03);
    check("raw_byte1", dec_b[1], 8'h00);
`endif

    // Full run, entry k = k % 11
    run(r_mod, 0, 1'b1, -1, '0);
`ifndef MATRIX_TX_ASCII_EN
    check("full_byte10", dec_b[10], 8'h0A);
    check("full_byte99", dec_b[99], 8'h00);
`endif

    // Start while busy with a different product is ignored
    run(r_mod, 0, 1'b1, 500, r_ff);

    // Reset during byte 7 bit 3, then a fresh transmission from entry 0
    run(r_mod, 7, 1'b0, -1, '0);
    repeat (CPB + 3 * CPB) @(negedge clk);
    check("byte7_bit3_low", tx, 1'b0);
    rst = 1'b1;
    #1;
    check("abort_tx_high", tx, 1'b1);
    check("abort_busy_low", busy, 1'b0);
    check("abort_no_done", done, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("after_abort_idle_tx", tx, 1'b1);
    run(r_b, 0, 1'b1, -1, '0);

`ifdef MATRIX_TX_ASCII_EN
    r_a = '0;
    r_a[3:0]   = 4'hA;
    r_a[39:36] = 4'h5;
    run(r_a, 0, 1'b1, -1, '0);
    check("ascii_byte0", dec_b[0], 8'h41);
    check("ascii_byte9", dec_b[9], 8'h35);
    check("ascii_byte10", dec_b[10], 8'h0D);
    check("ascii_byte11", dec_b[11], 8'h0A);
    check("ascii_frames", nfr, 120);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
